// File: rtl/counter_ctrl.sv
// Control side of the interval counter: command pulses -> state code, interval/limit registers, limit detect.
// Optional COUNTER_CTRL_AUTO_RELOAD_EN: restart through a one-cycle RESET on limit and count periods on reload_cnt.
module counter_ctrl #(
   parameter logic [31:0] INTERVAL_INIT = 32'd49_999_999,
   parameter logic [31:0] LIMIT_INIT    = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_start,
   input  logic        cmd_stop,
   input  logic        cmd_clear,
   input  logic [31:0] cfg_interval,
   input  logic [31:0] cfg_limit,
   input  logic        cfg_load,
   input  logic [31:0] counter_in,
   output logic [7:0]  state,
   output logic [31:0] interval,
   output logic        running,
   output logic        done,
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
   output logic [15:0] reload_cnt,
`endif
   output logic        cfg_err
);

   // state   | meaning
   // S_IDLE  | cleared, code RESET
   // S_RUN   | counting, code RUN
   // S_PAUSE | paused by cmd_stop, code HALT
   // S_DONE  | limit reached, code HALT, needs clear
   // S_RELD  | auto-reload restart cycle, code RESET
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_DONE  = 3'd3,
      S_RELD  = 3'd4
   } fsm_t;

   localparam logic [7:0] CODE_RESET = 8'd0;
   localparam logic [7:0] CODE_RUN   = 8'd1;
   localparam logic [7:0] CODE_HALT  = 8'd2;

   fsm_t        fsm, fsm_next;
   logic [31:0] limit;
   logic        hit;
   logic        done_next;
   logic        cfg_ok;
   logic [7:0]  code_next;

   assign hit    = (fsm == S_RUN) && (limit != 32'd0) && (counter_in >= limit);
   assign cfg_ok = (fsm == S_IDLE) || (fsm == S_PAUSE);

   always_comb begin
      fsm_next  = fsm;
      done_next = 1'b0;
      if (cmd_clear) begin
         fsm_next = S_IDLE;
      end else if (cmd_stop) begin
         if (fsm == S_RUN || fsm == S_RELD)
            fsm_next = S_PAUSE;
      end else if (hit) begin
         done_next = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
         fsm_next  = S_RELD;
`else
         fsm_next  = S_DONE;
`endif
      end else if (cmd_start && (fsm == S_IDLE || fsm == S_PAUSE)) begin
         fsm_next = S_RUN;
      end else if (fsm == S_RELD) begin
         fsm_next = S_RUN;
      end
   end

   always_comb begin
      code_next = CODE_RESET;
      case (fsm_next)
         S_IDLE:  code_next = CODE_RESET;
         S_RUN:   code_next = CODE_RUN;
         S_PAUSE: code_next = CODE_HALT;
         S_DONE:  code_next = CODE_HALT;
         S_RELD:  code_next = CODE_RESET;
         default: code_next = CODE_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm      <= S_IDLE;
         state    <= CODE_RESET;
         running  <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
         interval <= INTERVAL_INIT;
         limit    <= LIMIT_INIT;
      end else begin
         fsm     <= fsm_next;
         state   <= code_next;
         running <= (fsm_next == S_RUN);
         done    <= done_next;
         cfg_err <= cfg_load && !cfg_ok;
         // config legality is judged on the pre-transition state
         if (cfg_load && cfg_ok) begin
            interval <= cfg_interval;
            limit    <= cfg_limit;
         end
      end
   end

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
   always_ff @(posedge clk) begin
      if (rst || cmd_clear)
         reload_cnt <= 16'd0;
      else if (done_next)
         reload_cnt <= reload_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Control-side partner of the free-running interval counter.
- Turns one-cycle start/stop/clear command pulses into the counter's 8-bit state code (RESET/RUN/HALT).
- Owns the programmable interval register and monitors the counter value fed back from the counter.
- Auto-halts at a programmable limit and reports completion. Sits between the button/command logic and the counter instance.

Parameters:
- INTERVAL_INIT, 32'd49_999_999, interval register value after reset.
- LIMIT_INIT, 32'd0, limit register value after reset; 0 = no limit.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle start/resume pulse.
- cmd_stop  in  1  one-cycle pause pulse.
- cmd_clear  in  1  one-cycle clear pulse.
- cfg_interval  in  32  new interval value.
- cfg_limit  in  32  new limit value.
- cfg_load  in  1  write cfg_interval/cfg_limit into the registers.
- counter_in  in  32  counter value fed back from the counter.
- state  out  8  counter state code: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT.
- interval  out  32  interval register to the counter.
- running  out  1  high while state==RUN.
- done  out  1  one-cycle pulse on limit reached.
- cfg_err  out  1  one-cycle pulse when cfg_load is ignored.

Behaviour:
- Internal FSM, all outputs registered:
  - IDLE: state = RESET.
  - RUN: state = RUN.
  - PAUSE: state = HALT.
  - DONE: state = HALT.
- Reset (rst=1 at a posedge): FSM=IDLE, state=8'd0, interval=INTERVAL_INIT, limit=LIMIT_INIT, running=0, done=0, cfg_err=0. rst overrides every other input, including mid-RUN.
- Command priority in one cycle: clear > stop > start. Lower-priority commands in the same cycle are dropped.
- cmd_clear, from any FSM state -> IDLE next cycle.
- cmd_start:
  - IDLE/PAUSE -> RUN.
  - RUN: no effect.
  - DONE: no effect; clear first.
- cmd_stop:
  - RUN -> PAUSE.
  - Other states: no effect.
- Limit detect:
  - Condition: FSM in RUN, limit != 0, counter_in >= limit (unsigned).
  - Result: FSM -> DONE next cycle, done=1 for exactly that cycle.
  - Limit detect beats cmd_start in the same cycle; cmd_stop and cmd_clear beat limit detect.
- Latency: command at edge N -> new state code visible after edge N+1 (one-cycle register latency).
- Counter overshoot: the counter value may pass limit by the increments of the detect cycle. Allowed; done timing is judged on counter_in.
- cfg_load:
  - Accepted only in IDLE or PAUSE; interval and limit update on the next edge.
  - In RUN or DONE: ignored, registers unchanged, cfg_err=1 for one cycle.
  - cfg_load together with a command: config is judged against the current (pre-transition) FSM state.
- interval = 0 is legal and passes through unchanged.
- running mirrors state==RUN with no additional latency beyond state.

Optional Feature:
- Macro: COUNTER_CTRL_AUTO_RELOAD_EN.
- Defined: on limit detect the FSM goes to RUN via a one-cycle RESET instead of to DONE.
  - Sequence: state=RESET for exactly one cycle, then RUN, with no command needed.
  - done pulses on each period.
  - A 16-bit output port reload_cnt counts completed periods (wraps 16'hFFFF->0), is reset by rst and cmd_clear, and is present only when the macro is defined.
  - cmd_stop during the RESET cycle -> PAUSE.
- Undefined: DONE behaviour as above; no reload_cnt port.

Test Plan:
- Reset/default: rst for 2 cycles -> state=8'd0, interval=49_999_999, running=0, done=0; hold, no commands -> outputs stable.
- Config + run:
  - In IDLE, cfg_load with cfg_interval=3, cfg_limit=5 -> interval=3 next cycle.
  - cmd_start -> state=8'd1 one cycle later.
  - Model counter_in stepping 0..5 -> done single pulse the cycle after counter_in=5, state=8'd2, running=0.
- Pause/resume: in RUN, cmd_stop -> state=8'd2; cfg_load interval=7 accepted; cmd_start -> state=8'd1 with interval=7, counter_in held value unaffected.
- Priority and illegal config:
  - cmd_start+cmd_stop+cmd_clear same cycle in RUN -> IDLE (state=8'd0).
  - cfg_load in RUN -> cfg_err pulse, interval unchanged.
  - cmd_start in DONE -> stays state=8'd2.
- Reset mid-operation: rst asserted in RUN with counter_in=3 and limit=5 -> next cycle state=8'd0, interval=INTERVAL_INIT, no done pulse.
- Auto-reload (macro on): limit=4, counter_in reaches 4 -> done pulse, state sequence 8'd0 for one cycle then 8'd1; reload_cnt 0->1; repeat 3 periods -> reload_cnt=3.
